// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port SRAM arbiter for IR/LD/ST with fetch anti-starvation and read-return tags
module mem_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ir_req,
  input  logic [ADDR_W-1:0] ir_adrs,
  output logic              ir_gnt,
  output logic              ir_rvalid,
  output logic [DATA_W-1:0] ir_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_adrs,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_adrs,
  input  logic [DATA_W-1:0] st_wdata,
  output logic              st_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adrs,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_IR   = 2'd1;
  localparam logic [1:0] TAG_LD   = 2'd2;

  logic [WAIT_W-1:0] ir_wait;
  logic              ir_promote;
  logic [1:0]        tag_in;
  logic [1:0]        tag_pipe [0:RD_LAT];

  // Winner selection: a starved fetch jumps the queue, otherwise ST > LD > IR
  always_comb begin
    ir_promote = ir_req && (ir_wait == WAIT_W'(MAX_WAIT));
    st_gnt     = 1'b0;
    ld_gnt     = 1'b0;
    ir_gnt     = 1'b0;
    if (!reset) begin
      if (ir_promote)  ir_gnt = 1'b1;
      else if (st_req) st_gnt = 1'b1;
      else if (ld_req) ld_gnt = 1'b1;
      else if (ir_req) ir_gnt = 1'b1;
    end
  end

  // Count consecutive lost fetch arbitrations, saturating at the promotion threshold
  always_ff @(posedge clk) begin
    if (reset || !ir_req || ir_gnt) begin
      ir_wait <= '0;
    end else if (ir_wait != WAIT_W'(MAX_WAIT)) begin
      ir_wait <= ir_wait + WAIT_W'(1);
    end
  end

  // Register the winner's access onto the SRAM port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_adrs  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= st_gnt | ld_gnt | ir_gnt;
      mem_we <= st_gnt;
      if (st_gnt) begin
        mem_adrs  <= st_adrs;
        mem_wdata <= st_wdata;
      end else if (ld_gnt) begin
        mem_adrs <= ld_adrs;
      end else if (ir_gnt) begin
        mem_adrs <= ir_adrs;
      end
    end
  end

  // Tag of the access granted this cycle; stores and idle cycles carry no return
  always_comb begin
    tag_in = TAG_NONE;
    if (ld_gnt)      tag_in = TAG_LD;
    else if (ir_gnt) tag_in = TAG_IR;
  end

  // Shift tags so the last stage lines up with the cycle the SRAM returns data
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i <= RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  // Steer returning read data to its requester; data is zero whenever not valid
  always_comb begin
    ir_rvalid = !reset && (tag_pipe[RD_LAT] == TAG_IR);
    ld_rvalid = !reset && (tag_pipe[RD_LAT] == TAG_LD);
    ir_rdata  = ir_rvalid ? mem_rdata : '0;
    ld_rdata  = ld_rvalid ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - testbench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 4;
  localparam int W_NONE = 0, W_IR = 1, W_LD = 2, W_ST = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              ir_req, ld_req, st_req;
  logic [ADDR_W-1:0] ir_adrs, ld_adrs, st_adrs;
  logic [DATA_W-1:0] st_wdata;
  logic              ir_gnt, ld_gnt, st_gnt;
  logic              ir_rvalid, ld_rvalid;
  logic [DATA_W-1:0] ir_rdata, ld_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_adrs;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ir_req(ir_req), .ir_adrs(ir_adrs), .ir_gnt(ir_gnt), .ir_rvalid(ir_rvalid), .ir_rdata(ir_rdata),
    .ld_req(ld_req), .ld_adrs(ld_adrs), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_adrs(st_adrs), .st_wdata(st_wdata), .st_gnt(st_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adrs(mem_adrs), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // SRAM model with RD_LAT=1: data for an access registered in cycle N appears in N+1
  logic [DATA_W-1:0] sram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en && mem_we)  sram[mem_adrs] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_adrs];
  end

  // Behavioural reference: memory contents in grant order plus a queue of due read returns
  typedef struct { int due; int who; logic [31:0] dat; } pend_t;
  pend_t             pend [$];
  logic [DATA_W-1:0] mmem [0:(1<<ADDR_W)-1];
  int                cyc = 0;
  int                m_lost = 0;
  logic              m_en = 1'b0, m_we = 1'b0;
  logic [ADDR_W-1:0] m_adrs = '0;
  logic [DATA_W-1:0] m_wdata = '0;

  always @(negedge clk) begin
    int   win;
    logic e_irv, e_ldv;
    logic [31:0] e_dat;
    if (armed) begin
      if (reset) win = W_NONE;
      else if (ir_req && m_lost >= MAX_WAIT) win = W_IR;
      else if (st_req) win = W_ST;
      else if (ld_req) win = W_LD;
      else if (ir_req) win = W_IR;
      else win = W_NONE;
      chk("m_st_gnt", st_gnt, win == W_ST);
      chk("m_ld_gnt", ld_gnt, win == W_LD);
      chk("m_ir_gnt", ir_gnt, win == W_IR);
      chk("m_mem_en", mem_en, m_en);
      chk("m_mem_we", mem_we, m_we);
      chk("m_mem_adrs", mem_adrs, m_adrs);
      chk("m_mem_wdata", mem_wdata, m_wdata);
      e_irv = 1'b0; e_ldv = 1'b0; e_dat = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (!reset) begin
          e_irv = (pend[0].who == W_IR);
          e_ldv = (pend[0].who == W_LD);
          e_dat = pend[0].dat;
        end
        void'(pend.pop_front());
      end
      chk("m_ir_rvalid", ir_rvalid, e_irv);
      chk("m_ld_rvalid", ld_rvalid, e_ldv);
      chk("m_ir_rdata", ir_rdata, e_irv ? e_dat : 32'h0);
      chk("m_ld_rdata", ld_rdata, e_ldv ? e_dat : 32'h0);
      if (reset) begin
        m_en = 1'b0; m_we = 1'b0; m_adrs = '0; m_wdata = '0; m_lost = 0;
        pend.delete();
      end else begin
        m_en = (win != W_NONE);
        m_we = (win == W_ST);
        if (win == W_ST) begin
          m_adrs = st_adrs; m_wdata = st_wdata; mmem[st_adrs] = st_wdata;
        end else if (win == W_LD) begin
          m_adrs = ld_adrs; pend.push_back('{cyc + 1 + RD_LAT, W_LD, mmem[ld_adrs]});
        end else if (win == W_IR) begin
          m_adrs = ir_adrs; pend.push_back('{cyc + 1 + RD_LAT, W_IR, mmem[ir_adrs]});
        end
        if (ir_req && win != W_IR) m_lost = (m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT;
        else m_lost = 0;
      end
    end
    cyc++;
  end

  logic              r_st[16], r_ld[16], r_ir[16], r_men[16], r_mwe[16], r_lrv[16], r_irv[16];
  logic [ADDR_W-1:0] r_madr[16];
  logic [DATA_W-1:0] r_lrd[16], r_ird[16];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Record outputs for n cycles; requesters drop req after their grant (ST held st_len cycles if >0)
  task automatic run(input int n, input int st_len);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      r_st[c] = st_gnt; r_ld[c] = ld_gnt; r_ir[c] = ir_gnt;
      r_men[c] = mem_en; r_mwe[c] = mem_we; r_madr[c] = mem_adrs;
      r_lrv[c] = ld_rvalid; r_lrd[c] = ld_rdata; r_irv[c] = ir_rvalid; r_ird[c] = ir_rdata;
      tick();
      if (st_len > 0) begin
        if (c + 1 >= st_len) st_req = 1'b0;
      end else if (r_st[c]) st_req = 1'b0;
      if (r_ld[c]) ld_req = 1'b0;
      if (r_ir[c]) ir_req = 1'b0;
    end
  endtask

  initial begin
    int lrv_cnt;
    for (int a = 0; a < (1 << ADDR_W); a++) begin
      sram[a] = 32'hA500_0000 | 32'(a);
      mmem[a] = 32'hA500_0000 | 32'(a);
    end
    mem_rdata = '0;
    reset = 1'b1;
    ir_req = 0; ld_req = 0; st_req = 0;
    ir_adrs = '0; ld_adrs = '0; st_adrs = '0; st_wdata = '0;
    tick();
    armed = 1'b1;
    @(negedge clk);
    chk("reset_mem_en", mem_en, 0);
    chk("reset_mem_adrs", mem_adrs, 0);
    tick();
    reset = 1'b0;
    tick();

    // fetch only
    ir_req = 1; ir_adrs = 11'h010;
    run(4, 0);
    chk("t1_ir_gnt_c0", r_ir[0], 1);
    chk("t1_mem_en_c0", r_men[0], 0);
    chk("t1_mem_en_c1", r_men[1], 1);
    chk("t1_mem_we_c1", r_mwe[1], 0);
    chk("t1_mem_adrs_c1", r_madr[1], 11'h010);
    chk("t1_ir_rvalid_c1", r_irv[1], 0);
    chk("t1_ir_rvalid_c2", r_irv[2], 1);
    chk("t1_ir_rdata_c2", r_ird[2], 32'hA500_0010);

    // all three at once
    st_req = 1; st_adrs = 11'h030; st_wdata = 32'h1234_5678;
    ld_req = 1; ld_adrs = 11'h031;
    ir_req = 1; ir_adrs = 11'h032;
    run(6, 0);
    chk("t2_st_gnt_c0", r_st[0], 1);
    chk("t2_ld_gnt_c1", r_ld[1], 1);
    chk("t2_ir_gnt_c2", r_ir[2], 1);
    chk("t2_mem_we_c1", r_mwe[1], 1);
    chk("t2_mem_adrs_c1", r_madr[1], 11'h030);
    chk("t2_mem_we_c2", r_mwe[2], 0);
    chk("t2_ld_rvalid_c3", r_lrv[3], 1);
    chk("t2_ld_rdata_c3", r_lrd[3], 32'hA500_0031);
    chk("t2_ir_rvalid_c4", r_irv[4], 1);
    chk("t2_ir_rdata_c4", r_ird[4], 32'hA500_0032);

    // fetch starvation under a continuous store stream
    st_req = 1; st_adrs = 11'h050; st_wdata = 32'h0000_0001;
    ir_req = 1; ir_adrs = 11'h060;
    run(12, 10);
    chk("t3_ir_gnt_c3", r_ir[3], 0);
    chk("t3_st_gnt_c3", r_st[3], 1);
    chk("t3_ir_gnt_c4", r_ir[4], 1);
    chk("t3_st_gnt_c4", r_st[4], 0);
    chk("t3_st_gnt_c5", r_st[5], 1);
    chk("t3_ir_rdata_c6", r_ird[6], 32'hA500_0060);

    // store then load to the same address
    st_req = 1; st_adrs = 11'h020; st_wdata = 32'hDEAD_BEEF;
    ld_req = 1; ld_adrs = 11'h020;
    run(5, 0);
    chk("t4_ld_gnt_c1", r_ld[1], 1);
    chk("t4_ld_rvalid_c3", r_lrv[3], 1);
    chk("t4_ld_rdata_c3", r_lrd[3], 32'hDEAD_BEEF);

    // reset right after a load grant kills the return
    ld_req = 1; ld_adrs = 11'h040;
    @(negedge clk);
    chk("t5_ld_gnt_c0", ld_gnt, 1);
    tick();
    ld_req = 0; reset = 1;
    @(negedge clk);
    chk("t5_ld_rvalid_c1", ld_rvalid, 0);
    tick();
    @(negedge clk);
    chk("t5_rst_mem_en", mem_en, 0);
    chk("t5_rst_mem_we", mem_we, 0);
    chk("t5_rst_mem_adrs", mem_adrs, 0);
    chk("t5_rst_mem_wdata", mem_wdata, 0);
    chk("t5_rst_ld_rvalid", ld_rvalid, 0);
    chk("t5_rst_ld_rdata", ld_rdata, 0);
    tick();
    reset = 0;
    run(4, 0);
    lrv_cnt = 0;
    for (int c = 0; c < 4; c++) lrv_cnt += int'(r_lrv[c]);
    chk("t5_no_ld_rvalid", lrv_cnt, 0);

    // load request withdrawn while losing to a store
    st_req = 1; st_adrs = 11'h070; st_wdata = 32'h0BAD_F00D;
    ld_req = 1; ld_adrs = 11'h071;
    @(negedge clk);
    chk("t6_st_gnt", st_gnt, 1);
    chk("t6_ld_gnt", ld_gnt, 0);
    tick();
    st_req = 0; ld_req = 0;
    run(4, 0);
    chk("t6_mem_we_c1", r_mwe[0], 1);
    chk("t6_mem_en_c2", r_men[1], 0);
    lrv_cnt = 0;
    for (int c = 0; c < 4; c++) lrv_cnt += int'(r_lrv[c]);
    chk("t6_no_ld_rvalid", lrv_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
